// File: rtl/port_array_gather_if.sv
// Stream-in / array-out bundle for port_array_gather.
//   in_valid/in_ready/in_data/in_last   : serial word stream into the gatherer
//   out_valid/out_ready/out_data[]      : assembled group, one word per element
//   out_count/out_trunc/err_overrun     : group length, truncation flag, sticky overrun
// master: upstream/downstream side (drives words and out_ready)
// slave : the gatherer itself
interface port_array_gather_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NWORDS = 2
);
    localparam int unsigned CW = $clog2(NWORDS + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data [NWORDS];
    logic [CW-1:0]    out_count;
    logic             out_trunc;
    logic             err_overrun;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_trunc, err_overrun
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_trunc, err_overrun
    );
endinterface

// File: rtl/port_array_gather.sv
// Gathers a serial valid/ready word stream into groups of up to NWORDS words and
// presents each group as an unpacked array on a second valid/ready handshake.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : port_array_gather_if.slave (input stream, output group, status)
// A group closes on in_last or when NWORDS words have been taken; the latter
// sets out_trunc and the sticky err_overrun. While a group is held, in_ready
// follows out_ready so a word can enter element 0 in the release cycle.
module port_array_gather #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NWORDS = 2
) (
    input  logic                clk,
    input  logic                reset,
    port_array_gather_if.slave  bus
);
    localparam int unsigned CW = $clog2(NWORDS + 1);
    localparam int unsigned IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NWORDS - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    w_idx_nxt;
    logic [WIDTH-1:0] r_data     [NWORDS];
    logic [WIDTH-1:0] w_data_nxt [NWORDS];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_trunc;
    logic             w_trunc_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_release;

    // Next-state and datapath update; defaults hold every register.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_count_nxt = r_count;
        w_trunc_nxt = r_trunc;
        w_err_nxt   = r_err;
        w_in_ready  = 1'b0;

        // Ready is forced low while reset is asserted, so no word is taken then.
        if (!reset) begin
            w_in_ready = (r_state == S_FILL) ? 1'b1 : bus.out_ready;
        end
        w_accept  = bus.in_valid & w_in_ready;
        w_release = (r_state == S_HOLD) & bus.out_ready;

        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    w_data_nxt[r_idx] = bus.in_data;
                    if (bus.in_last || (r_idx == IDX_LAST)) begin
                        w_state_nxt = S_HOLD;
                        w_idx_nxt   = '0;
                        w_count_nxt = CW'(r_idx) + CW'(1);
                        w_trunc_nxt = ~bus.in_last;
                        w_err_nxt   = r_err | ~bus.in_last;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end
            end

            S_HOLD: begin
                if (w_release) begin
                    // Released group clears so unwritten elements read zero next time.
                    for (int unsigned i = 0; i < NWORDS; i++) begin
                        w_data_nxt[i] = '0;
                    end
                    w_state_nxt = S_FILL;
                    w_idx_nxt   = '0;
                    w_count_nxt = '0;
                    w_trunc_nxt = 1'b0;
                    if (w_accept) begin
                        w_data_nxt[0] = bus.in_data;
                        if (bus.in_last || (NWORDS == 1)) begin
                            // The incoming word closes a new group immediately.
                            w_state_nxt = S_HOLD;
                            w_count_nxt = CW'(1);
                            w_trunc_nxt = ~bus.in_last;
                            w_err_nxt   = r_err | ~bus.in_last;
                        end else begin
                            w_idx_nxt = IW'(1);
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    // State and group registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FILL;
            r_idx   <= '0;
            for (int unsigned i = 0; i < NWORDS; i++) begin
                r_data[i] <= '0;
            end
            r_count <= '0;
            r_trunc <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            for (int unsigned i = 0; i < NWORDS; i++) begin
                r_data[i] <= w_data_nxt[i];
            end
            r_count <= w_count_nxt;
            r_trunc <= w_trunc_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = (r_state == S_HOLD);
    assign bus.out_count   = r_count;
    assign bus.out_trunc   = r_trunc;
    assign bus.err_overrun = r_err;

    for (genvar g = 0; g < NWORDS; g++) begin : g_out
        assign bus.out_data[g] = r_data[g];
    end
endmodule

// File: tb/tb_port_array_gather.sv
// Bench for port_array_gather: a 2-word instance for grouping, truncation,
// hold and reset scenarios, and a 1-word instance for full-rate streaming.
module tb_port_array_gather;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    port_array_gather_if #(.WIDTH(32), .NWORDS(2)) bus2 ();
    port_array_gather_if #(.WIDTH(32), .NWORDS(1)) bus1 ();

    port_array_gather #(.WIDTH(32), .NWORDS(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    port_array_gather #(.WIDTH(32), .NWORDS(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        int unsigned cnt;
        bit          trunc;
    } grp_t;

    grp_t        q2[$];
    grp_t        q1[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_w[2];
    int unsigned m_n = 0;

    // Reference grouping for the 2-word instance.
    function automatic void model_push(input logic [31:0] d, input bit last);
        grp_t g;
        if (m_n == 0) begin
            m_w[0] = '0;
            m_w[1] = '0;
        end
        m_w[m_n] = d;
        m_n++;
        if (last || m_n == 2) begin
            g.d0    = m_w[0];
            g.d1    = m_w[1];
            g.cnt   = m_n;
            g.trunc = !last;
            q2.push_back(g);
            m_n = 0;
        end
    endfunction

    // Scoreboard for the 2-word instance: compare on every output handshake.
    always @(negedge clk) begin
        grp_t g;
        if (!reset && bus2.out_valid && bus2.out_ready) begin
            n_tests++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL grp2_unexpected got d0=%h d1=%h cnt=%0d, expected no group",
                         bus2.out_data[0], bus2.out_data[1], bus2.out_count);
            end else begin
                g = q2.pop_front();
                if (bus2.out_data[0] !== g.d0 || bus2.out_data[1] !== g.d1 ||
                    bus2.out_count !== 2'(g.cnt) || bus2.out_trunc !== g.trunc) begin
                    n_fail++;
                    $display("FAIL grp2 got d0=%h d1=%h cnt=%0d trunc=%0b expected d0=%h d1=%h cnt=%0d trunc=%0b",
                             bus2.out_data[0], bus2.out_data[1], bus2.out_count, bus2.out_trunc,
                             g.d0, g.d1, g.cnt, g.trunc);
                end
            end
        end
    end

    // Scoreboard for the 1-word instance.
    always @(negedge clk) begin
        grp_t g;
        if (!reset && bus1.out_valid && bus1.out_ready) begin
            n_tests++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL grp1_unexpected got d0=%h, expected no group", bus1.out_data[0]);
            end else begin
                g = q1.pop_front();
                if (bus1.out_data[0] !== g.d0 || bus1.out_count !== 1'(g.cnt) ||
                    bus1.out_trunc !== g.trunc) begin
                    n_fail++;
                    $display("FAIL grp1 got d0=%h cnt=%0d trunc=%0b expected d0=%h cnt=%0d trunc=%0b",
                             bus1.out_data[0], bus1.out_count, bus1.out_trunc, g.d0, g.cnt, g.trunc);
                end
            end
        end
    end

    // Offer one word to the 2-word instance; returns just after it is accepted.
    task automatic send2(input logic [31:0] d, input bit last);
        int t;
        bus2.in_valid = 1'b1;
        bus2.in_data  = d;
        bus2.in_last  = last;
        model_push(d, last);
        t = 0;
        @(negedge clk);
        while (!bus2.in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (t >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL send2_timeout in_ready=%0b expected 1", bus2.in_ready);
        end
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        bus2.in_last  = 1'b0;
    endtask

    task automatic wait_drain2(input string name);
        int t;
        t = 0;
        while (q2.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (q2.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain pending=%0d expected 0", name, q2.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_last = 1'b0; bus2.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_last = 1'b0; bus1.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus2.in_ready !== 1'b0 || bus2.out_valid !== 1'b0 || bus2.out_count !== 2'd0 ||
            bus2.out_trunc !== 1'b0 || bus2.err_overrun !== 1'b0 ||
            bus2.out_data[0] !== 32'd0 || bus2.out_data[1] !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values rdy=%0b vld=%0b cnt=%0d tr=%0b err=%0b d0=%h d1=%h expected all 0",
                     bus2.in_ready, bus2.out_valid, bus2.out_count, bus2.out_trunc,
                     bus2.err_overrun, bus2.out_data[0], bus2.out_data[1]);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus2.in_ready !== 1'b1 || bus2.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release rdy2=%0b vld2=%0b rdy1=%0b expected 1 0 1",
                     bus2.in_ready, bus2.out_valid, bus1.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        send2(32'h1111_1111, 1'b0);
        send2(32'h2222_2222, 1'b1);
        @(negedge clk);
        n_tests++;
        if (bus2.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency out_valid=%0b expected 1", bus2.out_valid);
        end
        wait_drain2("basic");
    endtask

    task automatic test_single;
        send2(32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        n_tests++;
        if (bus2.out_data[1] !== 32'd0 || bus2.out_count !== 2'd1) begin
            n_fail++;
            $display("FAIL single d1=%h cnt=%0d expected 0 1", bus2.out_data[1], bus2.out_count);
        end
        wait_drain2("single");
    endtask

    task automatic test_trunc;
        send2(32'd1, 1'b0);
        send2(32'd2, 1'b0);
        send2(32'd3, 1'b1);
        wait_drain2("trunc");
        n_tests++;
        if (bus2.err_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL trunc_err err_overrun=%0b expected 1", bus2.err_overrun);
        end
    endtask

    task automatic test_hold;
        bus2.out_ready = 1'b0;
        send2(32'hAAAA_0001, 1'b0);
        send2(32'hAAAA_0002, 1'b1);
        bus2.in_valid = 1'b1;
        bus2.in_data  = 32'hCCCC_0003;
        bus2.in_last  = 1'b0;
        model_push(32'hCCCC_0003, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (bus2.in_ready !== 1'b0 || bus2.out_valid !== 1'b1 ||
                bus2.out_data[0] !== 32'hAAAA_0001 || bus2.out_data[1] !== 32'hAAAA_0002) begin
                n_fail++;
                $display("FAIL hold_c%0d rdy=%0b vld=%0b d0=%h d1=%h expected 0 1 aaaa0001 aaaa0002",
                         c, bus2.in_ready, bus2.out_valid, bus2.out_data[0], bus2.out_data[1]);
            end
        end
        @(posedge clk);
        #1;
        bus2.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus2.out_valid !== 1'b0 || bus2.out_data[0] !== 32'hCCCC_0003 || bus2.out_data[1] !== 32'd0) begin
            n_fail++;
            $display("FAIL hold_capture vld=%0b d0=%h d1=%h expected 0 cccc0003 0",
                     bus2.out_valid, bus2.out_data[0], bus2.out_data[1]);
        end
        @(posedge clk);
        #1;
        send2(32'hDDDD_0004, 1'b1);
        wait_drain2("hold");
        n_tests++;
        if (bus2.err_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky err_overrun=%0b expected 1", bus2.err_overrun);
        end
    endtask

    task automatic test_back_to_back;
        grp_t g;
        for (int k = 0; k < 9; k++) begin
            bus1.in_valid = 1'b1;
            bus1.in_data  = 32'hA000_0000 + 32'(k);
            bus1.in_last  = (k != 8);
            g.d0 = 32'hA000_0000 + 32'(k);
            g.d1 = '0;
            g.cnt = 1;
            g.trunc = (k == 8);
            q1.push_back(g);
            @(negedge clk);
            n_tests++;
            if (bus1.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready_k%0d in_ready=%0b expected 1", k, bus1.in_ready);
            end
            @(posedge clk);
            #1;
        end
        bus1.in_valid = 1'b0;
        bus1.in_last  = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (q1.size() != 0 || bus1.err_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_end pending=%0d err=%0b expected 0 1", q1.size(), bus1.err_overrun);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        send2(32'h5555_0001, 1'b0);
        reset = 1'b1;
        m_n = 0;
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if (bus2.out_valid !== 1'b0 || bus2.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid vld=%0b rdy=%0b expected 0 0", bus2.out_valid, bus2.in_ready);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus2.err_overrun !== 1'b0 || bus2.out_data[0] !== 32'd0 || bus2.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_after err=%0b d0=%h vld=%0b expected 0 0 0",
                     bus2.err_overrun, bus2.out_data[0], bus2.out_valid);
        end
        @(posedge clk);
        #1;
        send2(32'hEEEE_0001, 1'b0);
        send2(32'hEEEE_0002, 1'b1);
        wait_drain2("reset_mid");
        // Reset while a group is held: out_valid must drop and no group is released.
        bus2.out_ready = 1'b0;
        send2(32'h7777_0001, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        q2.delete();
        m_n = 0;
        @(negedge clk);
        n_tests++;
        if (bus2.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold out_valid=%0b expected 0", bus2.out_valid);
        end
        reset = 1'b0;
        bus2.out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_single;
        test_trunc;
        test_hold;
        test_back_to_back;
        test_reset_mid;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
